// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a function of registered state and flush only, never of out_ready.
// Flush squashes held tokens; halted records that a halt token reached downstream.
module pipe_stage_buf #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occupancy
);

  // Main entry drives the outputs; skid entry is always the younger token.
  logic              m_v_q, m_v_d, s_v_q, s_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic              m_h_q, m_h_d, s_h_q, s_h_d;
  logic              halt_seen_q, halt_seen_d;
  logic              halted_q, halted_d;
  logic              acc, dq;

  assign in_ready  = ~s_v_q & ~halt_seen_q & ~flush;
  assign out_valid = m_v_q;
  assign out_data  = m_d_q;
  assign out_halt  = m_h_q & m_v_q;
  assign halted    = halted_q;
  assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

  assign acc = in_valid & in_ready;
  assign dq  = m_v_q & out_ready;

  // Next-state for both entries, halt tracking and the sticky halted flag.
  always_comb begin
    m_v_d       = m_v_q;
    s_v_d       = s_v_q;
    m_d_d       = m_d_q;
    s_d_d       = s_d_q;
    m_h_d       = m_h_q;
    s_h_d       = s_h_q;
    halt_seen_d = halt_seen_q;
    halted_d    = halted_q | (dq & m_h_q);

    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
      if (CLEAR_DATA) begin
        m_d_d = '0;
        s_d_d = '0;
        m_h_d = 1'b0;
        s_h_d = 1'b0;
      end
      // A squashed halt must reopen the stage, but a delivered one keeps it closed.
      halt_seen_d = halted_d;
    end else begin
      if (acc && in_halt) begin
        halt_seen_d = 1'b1;
      end
      if (!m_v_q) begin
        if (acc) begin
          m_v_d = 1'b1;
          m_d_d = in_data;
          m_h_d = in_halt;
        end
      end else if (!dq) begin
        if (acc) begin
          s_v_d = 1'b1;
          s_d_d = in_data;
          s_h_d = in_halt;
        end
      end else if (s_v_q) begin
        // in_ready is low while skid is full, so no accept can race this move.
        m_d_d = s_d_q;
        m_h_d = s_h_q;
        s_v_d = 1'b0;
      end else if (acc) begin
        m_d_d = in_data;
        m_h_d = in_halt;
      end else begin
        m_v_d = 1'b0;
      end
    end
  end

  // Control state: valid bits and halt flags, synchronous reset has top priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_v_q       <= 1'b0;
      s_v_q       <= 1'b0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      m_v_q       <= m_v_d;
      s_v_q       <= s_v_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

  // Payload registers: cleared on reset only when CLEAR_DATA is set.
  always_ff @(posedge CLK) begin
    if (RST && CLEAR_DATA) begin
      m_d_q <= '0;
      s_d_q <= '0;
      m_h_q <= 1'b0;
      s_h_q <= 1'b0;
    end else begin
      m_d_q <= m_d_d;
      s_d_q <= s_d_d;
      m_h_q <= m_h_d;
      s_h_q <= s_h_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: two instances (payload clear on/off) against a queue-based model.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        RST, in_valid, in_halt, flush, out_ready;
  logic [31:0] in_data;

  logic        ir_c, ov_c, oh_c, hd_c;
  logic [31:0] od_c;
  logic [1:0]  occ_c;
  logic        ir_n, ov_n, oh_n, hd_n;
  logic [31:0] od_n;
  logic [1:0]  occ_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of held tokens plus flags.
  logic [31:0] q_d[$];
  bit          q_h[$];
  bit          m_hs, m_hd;
  logic [31:0] lm_c, lm_n;
  bit          n_known;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(32), .CLEAR_DATA(1'b1)) u_dut_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .in_halt(in_halt), .flush(flush), .out_valid(ov_c), .out_ready(out_ready),
    .out_data(od_c), .out_halt(oh_c), .halted(hd_c), .occupancy(occ_c)
  );

  pipe_stage_buf #(.DATA_W(32), .CLEAR_DATA(1'b0)) u_dut_n (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_n), .in_data(in_data),
    .in_halt(in_halt), .flush(flush), .out_valid(ov_n), .out_ready(out_ready),
    .out_data(od_n), .out_halt(oh_n), .halted(hd_n), .occupancy(occ_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit          exp_ir, exp_ov, exp_oh;
    logic [31:0] exp_occ;
    exp_ir  = !flush && !m_hs && (q_d.size() < 2);
    exp_ov  = q_d.size() > 0;
    exp_oh  = exp_ov ? q_h[0] : 1'b0;
    exp_occ = q_d.size();
    check_eq("in_ready_c", 32'(ir_c), 32'(exp_ir));
    check_eq("in_ready_n", 32'(ir_n), 32'(exp_ir));
    check_eq("out_valid_c", 32'(ov_c), 32'(exp_ov));
    check_eq("out_valid_n", 32'(ov_n), 32'(exp_ov));
    check_eq("out_halt_c", 32'(oh_c), 32'(exp_oh));
    check_eq("out_halt_n", 32'(oh_n), 32'(exp_oh));
    check_eq("halted_c", 32'(hd_c), 32'(m_hd));
    check_eq("halted_n", 32'(hd_n), 32'(m_hd));
    check_eq("occupancy_c", 32'(occ_c), exp_occ);
    check_eq("occupancy_n", 32'(occ_n), exp_occ);
    check_eq("out_data_c", od_c, lm_c);
    if (n_known) check_eq("out_data_n", od_n, lm_n);
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_update();
    bit ir, acc, dq;
    ir  = !flush && !m_hs && (q_d.size() < 2);
    acc = in_valid && ir;
    dq  = (q_d.size() > 0) && out_ready;
    if (RST) begin
      q_d.delete();
      q_h.delete();
      m_hs    = 1'b0;
      m_hd    = 1'b0;
      lm_c    = '0;
      n_known = 1'b0;
    end else begin
      if (dq) begin
        if (q_h[0]) m_hd = 1'b1;
        void'(q_d.pop_front());
        void'(q_h.pop_front());
      end
      if (flush) begin
        q_d.delete();
        q_h.delete();
        m_hs = m_hd;
        lm_c = '0;
      end else begin
        if (acc) begin
          q_d.push_back(in_data);
          q_h.push_back(in_halt);
          if (in_halt) m_hs = 1'b1;
        end
        if (q_d.size() > 0) begin
          lm_c    = q_d[0];
          lm_n    = q_d[0];
          n_known = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [31:0] d, input bit h,
                      input bit fl, input bit ordy);
    RST       = r;
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    flush     = fl;
    out_ready = ordy;
    #1;
    check_outputs();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; in_halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge CLK);
    model_update();
    @(negedge CLK);

    // Streaming at full rate.
    step(0, 1, 32'h11, 0, 0, 1);
    step(0, 1, 32'h22, 0, 0, 1);
    step(0, 1, 32'h33, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Back-pressure then drain in order.
    step(0, 1, 32'hA1, 0, 0, 0);
    step(0, 1, 32'hA2, 0, 0, 0);
    step(0, 1, 32'hA3, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Flush while full with an input offered.
    step(0, 1, 32'hB1, 0, 0, 0);
    step(0, 1, 32'hB2, 0, 0, 0);
    step(0, 1, 32'hFF, 0, 1, 0);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Halt: later tokens refused, halted sticky through flush.
    step(0, 1, 32'h05, 1, 0, 0);
    step(0, 1, 32'h06, 0, 0, 0);
    step(0, 1, 32'h06, 0, 0, 1);
    step(0, 1, 32'h06, 0, 0, 1);
    step(0, 0, 32'h0, 0, 1, 1);
    step(0, 1, 32'h07, 0, 0, 1);
    step(1, 0, 32'h0, 0, 0, 0);

    // Squashed halt reopens the stage.
    step(0, 1, 32'h08, 1, 0, 0);
    step(0, 1, 32'h09, 0, 1, 0);
    step(0, 1, 32'h0A, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Mid-stream reset while full.
    step(0, 1, 32'hC1, 0, 0, 0);
    step(0, 1, 32'hC2, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 70,
           $urandom(),
           $urandom_range(99) < 4,
           $urandom_range(99) < 5,
           $urandom_range(99) < 60);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB), generalised to any payload width.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is a pure register function with no combinational path from out_ready.
- Adds flush with an optional payload clear, and sticky halt tracking.
- Sits between any two pipeline stages. Upstream sees back-pressure; downstream sees valid-tagged tokens.

Parameters:
- DATA_W, 32: payload width in bits (instr, npc, aluout, control, etc. concatenated by the wrapper).
- CLEAR_DATA, 1: 1 = flush and reset zero the payload registers; 0 = only the valid bits are cleared.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  upstream token present
- in_ready  out  1  stage can accept a token this cycle
- in_data  in  DATA_W  upstream payload
- in_halt  in  1  token is a halt instruction
- flush  in  1  squash all held tokens this cycle
- out_valid  out  1  head token present
- out_ready  in  1  downstream accepts the head this cycle
- out_data  out  DATA_W  head payload
- out_halt  out  1  head token is a halt
- halted  out  1  sticky: a halt token has been delivered downstream
- occupancy  out  2  number of held tokens, 0..2

Behaviour:
- Storage:
  - Main entry (m_v, m_d, m_h) drives out_*.
  - Skid entry (s_v, s_d, s_h) is always younger than main.
  - Invariant: s_v implies m_v.
- Handshake:
  - acc = in_valid & in_ready.
  - dq = out_valid & out_ready.
  - in_ready = !s_v & !halt_seen & !flush.
  - in_ready must not depend combinationally on out_ready.
- Outputs:
  - out_valid = m_v, out_data = m_d, out_halt = m_h & m_v.
  - occupancy = m_v + s_v.
- Latency and throughput:
  - Empty stage: a token accepted in cycle N appears on out_* in cycle N+1.
  - Sustained throughput is 1 token/cycle while out_ready = 1.
- Next-state, non-flush cycles:
  - !m_v & acc → main ← in.
  - m_v & !dq & acc → skid ← in.
  - m_v & dq & !s_v & acc → main ← in.
  - m_v & dq & !s_v & !acc → m_v ← 0.
  - m_v & dq & s_v → main ← skid, s_v ← 0. No accept is possible, since in_ready = 0.
  - Otherwise hold. Payload registers not loaded retain their value.
- Flush:
  - m_v and s_v ← 0 at the next edge.
  - If CLEAR_DATA = 1, m_d and s_d ← 0 and m_h and s_h ← 0.
  - in_ready is 0 during flush, so no input is taken.
  - A dq occurring in the same cycle is still a valid delivery: downstream sampled it.
- halt_seen (internal):
  - Set on acc & in_halt; in_ready drops to 0 from the next cycle.
  - Cleared by a flush, unless halted is already 1 (a squashed halt must not freeze the stage).
- halted:
  - Set on dq & m_h.
  - Stays 1 until RST; flush does not clear it.
  - Once halted = 1, halt_seen stays 1, so the stage stays closed.
- Reset:
  - At the edge with RST = 1, all valid bits, halt_seen, halted and occupancy ← 0.
  - Payload ← 0 if CLEAR_DATA, else don't-care.
  - RST has priority over flush and handshake.
  - A mid-stream reset discards held tokens without delivering them.
- Boundary cases:
  - Full (occupancy 2): in_ready = 0. A dq in the same cycle does not open the stage until the next cycle.
  - Full and out_ready held low: tokens held indefinitely, data stable.
  - in_valid & flush in the same cycle: the token is dropped and upstream sees in_ready = 0.
  - out_ready asserted while empty: no effect.

Test Plan:
- Streaming: RST, then tokens 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 1 → out_data 0x11, 0x22, 0x33 on cycles 1..3 after acceptance, occupancy never exceeds 1, in_ready constant 1.
- Back-pressure: 0xA1, 0xA2 with out_ready = 0 → occupancy = 2 and in_ready = 0 on the following cycle. Raise out_ready → 0xA1 then 0xA2 in order; in_ready = 1 only after the skid entry drains.
- Flush when full: occupancy 2, assert flush with in_valid = 1 and in_data 0xFF → next cycle out_valid = 0, occupancy = 0, 0xFF never appears, out_data = 0 (CLEAR_DATA = 1). Repeat with CLEAR_DATA = 0 → out_data retains its old value, out_valid = 0.
- Halt: accept 0x05 with in_halt = 1, followed by in_valid = 1 with 0x06 → in_ready = 0 from the next cycle and 0x06 is never accepted. Upon delivery of 0x05, halted = 1; a later flush leaves halted = 1.
- Squashed halt: accept a halt token, then flush before delivery → halted = 0 and in_ready returns to 1 on the next cycle.
- Sync reset mid-stream: occupancy 2, assert RST for 1 cycle with out_ready = 1 → after that edge, out_valid = 0, occupancy = 0, halted = 0. Verify no change occurs without a clock edge.
